// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the nibble-serial adder slice.
//   state_t  : controller state encoding (IDLE, RUN, DONE)
//   NIBBLE_W : width of the arithmetic core slice, in bits
package adder_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla.sv
// cla: 4-bit carry-lookahead adder, purely combinational.
//   a, b : 4-bit addends
//   cin  : carry in
//   sum  : a + b + cin (low 4 bits)
//   cout : carry out of bit 3
module cla (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      // Each carry is expanded from generate/propagate terms rather than rippled.
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum  = p ^ c[3:0];
      cout = c[4];
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that pushes one nibble per clock
// through a single 4-bit cla, LSB nibble first, with a registered carry.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin latched on accept)
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : registered result, carry out, signed overflow
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NIB   = WIDTH / NIBBLE_W;
   localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic [WIDTH-1:0]     sum_q, sum_d;
   logic                 carry_q, carry_d;
   logic                 cout_q, cout_d;
   logic                 ovf_q, ovf_d;

   logic [NIBBLE_W-1:0]  cla_a, cla_b, cla_sum;
   logic                 cla_cout;
   logic                 accept;
   logic                 last_nib;

   cla u_cla (
      .a    (cla_a),
      .b    (cla_b),
      .cin  (carry_q),
      .sum  (cla_sum),
      .cout (cla_cout)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = RUN;
         RUN:     if (last_nib)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Handshake outputs; rst gating keeps both low during any reset cycle.
   always_comb begin
      in_ready  = (state_q == IDLE) & ~rst;
      out_valid = (state_q == DONE) & ~rst;
   end

   // Datapath
   always_comb begin
      accept   = in_valid & in_ready;
      last_nib = (idx_q == IDX_LAST);
      cla_a    = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
      cla_b    = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      if (accept) begin
         a_d     = a;
         b_d     = b;
         carry_d = cin;
         idx_d   = '0;
      end

      if (state_q == RUN) begin
         res_d[idx_q*NIBBLE_W +: NIBBLE_W] = cla_sum;
         carry_d = cla_cout;
         if (last_nib) begin
            idx_d = '0;
            // res_q is a scratch accumulator; the visible result is copied
            // out only on DONE entry so sum/cout/ovf stay stable while busy.
            sum_d  = res_d;
            cout_d = cla_cout;
            ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (res_d[WIDTH-1] != a_q[WIDTH-1]);
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      sum  = sum_q;
      cout = cout_q;
      ovf  = ovf_q;
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: self-checking bench for nibble_serial_adder,
// covering WIDTH=16 (main instance) and WIDTH=4 (second instance).
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, sum;
   logic        cin, cout, ovf;

   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0]  a4, b4, sum4;
   logic        cin4, cout4, ovf4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic; {ovf, cout, sum}
   function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                           input logic c);
      int unsigned u;
      int          s;
      logic        ov;
      u  = 32'(x) + 32'(y) + 32'(c);
      s  = int'($signed(x)) + int'($signed(y)) + int'(c);
      ov = (s > 32767) || (s < -32768);
      return {ov, u[16], u[15:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with hold cycles of backpressure; checks latency,
   // results, and the state right after the output handshake.
   task automatic do_op(input string nm, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input int hold, input logic [17:0] exp);
      int w;
      int lat;
      w = 0;
      while (!in_ready && w < 50) begin tick(); w++; end
      chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
      a = av; b = bv; cin = ci; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin tick(); lat++; end
      chk({nm, ".latency"}, 32'(lat), 32'd4);
      chk({nm, ".result"}, 32'({ovf, cout, sum}), 32'(exp));
      repeat (hold) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, ".post_hs"}, 32'({out_valid, in_ready}), 32'b01);
   endtask

   initial begin
      vec_t tbl[6];
      logic [17:0] r;
      logic [15:0] hs;
      logic        hc, ho;
      int          bad, pulses, lat;
      int          acc, outs, acc_cyc[3];
      logic [15:0] ba[3], bb[3];

      tbl[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[1] = '{16'h7777, 16'h7777, 1'b0, 16'hEEEE, 1'b0, 1'b1};
      tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
      tbl[5] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.outputs", 32'({out_valid, cout, ovf, sum}), 32'd0);
      rst = 1'b0;
      tick();
      chk("rst.release_in_ready", 32'(in_ready), 32'd1);

      // Directed table
      foreach (tbl[i])
         do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, i % 2,
               {tbl[i].ov, tbl[i].co, tbl[i].s});

      // Backpressure with operand toggling while busy
      a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin a = ~a; b = b + 16'd3; tick(); lat++; end
      chk("bp.result", 32'({ovf, cout, sum}), 32'({1'b0, 1'b0, 16'h5555}));
      hs = sum; hc = cout; ho = ovf; bad = 0;
      for (int i = 0; i < 10; i++) begin
         a = 16'($urandom);
         tick();
         if (sum !== hs || cout !== hc || ovf !== ho || in_ready !== 1'b0 || out_valid !== 1'b1)
            bad++;
      end
      chk("bp.stable_cycles_bad", 32'(bad), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp.post_hs", 32'({out_valid, in_ready}), 32'b01);

      // Reset mid-RUN after two nibbles
      a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      chk("midrst.during", 32'({out_valid, in_ready}), 32'b00);
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) pulses++;
         tick();
      end
      chk("midrst.no_out_valid", 32'(pulses), 32'd0);
      do_op("midrst.next", 16'h1234, 16'h1111, 1'b0, 0, {1'b0, 1'b0, 16'h2345});

      // Randomized against the reference model
      for (int i = 0; i < 30; i++) begin
         logic [15:0] ra, rb;
         logic        rc;
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         if (i % 5 == 0) rb = ~ra;
         r = ref_add(ra, rb, rc);
         do_op($sformatf("rnd%0d", i), ra, rb, rc, int'($urandom_range(0, 3)), r);
      end

      // Back-to-back with in_valid and out_ready held high
      ba[0] = 16'h0F0F; bb[0] = 16'h00F1;
      ba[1] = 16'hABCD; bb[1] = 16'h5433;
      ba[2] = 16'h8001; bb[2] = 16'hFFFF;
      acc = 0; outs = 0;
      out_ready = 1'b1; in_valid = 1'b1;
      for (int cyc = 0; cyc < 60 && outs < 3; cyc++) begin
         if (out_valid) begin
            r = ref_add(ba[outs], bb[outs], 1'b0);
            chk($sformatf("b2b.result%0d", outs), 32'({ovf, cout, sum}), 32'(r));
            outs++;
         end
         if (in_ready) begin
            if (acc < 3) begin
               a = ba[acc]; b = bb[acc]; cin = 1'b0;
               acc_cyc[acc] = cyc;
               acc++;
            end else begin
               in_valid = 1'b0;
            end
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b.outputs", 32'(outs), 32'd3);
      chk("b2b.ii01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      chk("b2b.ii12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);

      // WIDTH=4 instance
      chk("w4.in_ready", 32'(in_ready4), 32'd1);
      a4 = 4'hE; b4 = 4'hC; cin4 = 1'b0; in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0; a4 = 4'h1; b4 = 4'h1;
      lat = 0;
      while (!out_valid4 && lat < 20) begin tick(); lat++; end
      chk("w4.latency", 32'(lat), 32'd1);
      chk("w4.result", 32'({ovf4, cout4, sum4}), 32'({1'b0, 1'b1, 4'hA}));
      out_ready4 = 1'b1;
      tick();
      chk("w4.post_hs", 32'({out_valid4, in_ready4}), 32'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
